// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU and a DMA/loader port.
// One transaction in flight at a time, with a registered memory request and an access timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last_d;
    logic               pick_d;
    logic               timed_out;
    logic [DATA_W-1:0]  rd_val;

    // DMA wins when it is the only requester, or on a tie when the CPU was served last
    assign pick_d    = d_req && (!c_req || !last_d);
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));
    assign rd_val    = (m_ack && !m_we) ? m_rdata : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last_d  <= 1'b1;
            grant   <= 2'b00;
            busy    <= 1'b0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            c_ack   <= 1'b0;
            d_ack   <= 1'b0;
            c_rdata <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_req || d_req) begin
                        state   <= ACCESS;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        m_req   <= 1'b1;
                        grant   <= pick_d ? 2'b10 : 2'b01;
                        m_we    <= pick_d ? d_we : c_we;
                        m_addr  <= pick_d ? d_addr : c_addr;
                        m_wdata <= pick_d ? d_wdata : c_wdata;
                    end
                end
                ACCESS: begin
                    // Completion and timeout share the same exit; rd_val is zero on timeout or write
                    if (m_ack || timed_out) begin
                        state   <= DONE;
                        m_req   <= 1'b0;
                        err     <= !m_ack;
                        c_ack   <= grant[0];
                        d_ack   <= grant[1];
                        c_rdata <= grant[0] ? rd_val : '0;
                        d_rdata <= grant[1] ? rd_val : '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    last_d  <= grant[1];
                    grant   <= 2'b00;
                    busy    <= 1'b0;
                    c_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    c_rdata <= '0;
                    d_rdata <= '0;
                    err     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              c_req, c_we, d_req, d_we;
    logic [ADDR_W-1:0] c_addr, d_addr;
    logic [DATA_W-1:0] c_wdata, d_wdata;
    logic              c_ack, d_ack, err, m_req, m_we, busy, m_ack;
    logic [DATA_W-1:0] c_rdata, d_rdata, m_wdata, m_rdata;
    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        grant;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .err(err), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .grant(grant), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        c_addr = 32'h100; d_addr = 32'h200; c_wdata = '0; d_wdata = '0;
        m_ack = 1'b1; m_rdata = 32'hA5A5_0001;
        tick(); tick();
        tests++;
        if ({grant, m_req, m_we, c_ack, d_ack, err, busy} !== 9'b0 || m_addr !== '0 || m_wdata !== '0
            || c_rdata !== '0 || d_rdata !== '0) begin
            fails++;
            $display("FAIL reset_outputs: grant=%b m_req=%b ack=%b%b err=%b busy=%b m_addr=%h required all 0",
                     grant, m_req, c_ack, d_ack, err, busy, m_addr);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (grant !== 2'b01 || m_req !== 1'b1 || m_addr !== 32'h100) begin
            fails++;
            $display("FAIL tie_first_grant: grant=%b m_req=%b m_addr=%h required 01 1 00000100", grant, m_req, m_addr);
        end
        tick();
        tests++;
        if (c_ack !== 1'b1 || d_ack !== 1'b0 || grant !== 2'b01 || c_rdata !== 32'hA5A5_0001) begin
            fails++;
            $display("FAIL tie_cpu_ack: c_ack=%b d_ack=%b grant=%b c_rdata=%h required 1 0 01 a5a50001",
                     c_ack, d_ack, grant, c_rdata);
        end
        c_req = 1'b0;
        tick();
        tests++;
        if (grant !== 2'b00 || c_ack !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL tie_idle: grant=%b c_ack=%b busy=%b required 00 0 0", grant, c_ack, busy);
        end
        tick();
        tests++;
        if (grant !== 2'b10 || m_addr !== 32'h200) begin
            fails++;
            $display("FAIL tie_dma_grant: grant=%b m_addr=%h required 10 00000200", grant, m_addr);
        end
        m_rdata = 32'hA5A5_0002;
        tick();
        tests++;
        if (d_ack !== 1'b1 || c_ack !== 1'b0 || d_rdata !== 32'hA5A5_0002) begin
            fails++;
            $display("FAIL tie_dma_ack: d_ack=%b c_ack=%b d_rdata=%h required 1 0 a5a50002", d_ack, c_ack, d_rdata);
        end
        d_req = 1'b0; m_ack = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0000_0010; m_ack = 1'b0;
        tick();
        tests++;
        if (m_req !== 1'b1 || grant !== 2'b01 || m_we !== 1'b0 || m_addr !== 32'h10 || busy !== 1'b1) begin
            fails++;
            $display("FAIL read_access1: m_req=%b grant=%b m_we=%b m_addr=%h busy=%b required 1 01 0 00000010 1",
                     m_req, grant, m_we, m_addr, busy);
        end
        tick();
        tests++;
        if (c_ack !== 1'b0 || m_req !== 1'b1) begin
            fails++;
            $display("FAIL read_access2: c_ack=%b m_req=%b required 0 1", c_ack, m_req);
        end
        m_ack = 1'b1; m_rdata = 32'h8C08_0004;
        tick();
        tests++;
        if (c_ack !== 1'b1 || c_rdata !== 32'h8C08_0004 || d_ack !== 1'b0 || err !== 1'b0 || m_req !== 1'b0) begin
            fails++;
            $display("FAIL read_done: c_ack=%b c_rdata=%h d_ack=%b err=%b m_req=%b required 1 8c080004 0 0 0",
                     c_ack, c_rdata, d_ack, err, m_req);
        end
        c_req = 1'b0; m_ack = 1'b0;
        tick();
        tests++;
        if (c_ack !== 1'b0 || busy !== 1'b0 || grant !== 2'b00) begin
            fails++;
            $display("FAIL read_idle: c_ack=%b busy=%b grant=%b required 0 0 00", c_ack, busy, grant);
        end
    endtask

    task automatic test_back_to_back();
        int n_c = 0;
        int n_d = 0;
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0; m_ack = 1'b1; m_rdata = 32'h1234_0000;
        // CPU was served last, so the DMA port takes the first tie
        for (int i = 0; i < 12; i++) begin
            logic exp_d;
            exp_d = (i % 2 == 0);
            tick();
            tests++;
            if (grant !== (exp_d ? 2'b10 : 2'b01) || m_req !== 1'b1) begin
                fails++;
                $display("FAIL b2b_grant[%0d]: grant=%b m_req=%b required %b 1", i, grant, m_req, exp_d ? 2'b10 : 2'b01);
            end
            tick();
            if (c_ack === 1'b1) n_c++;
            if (d_ack === 1'b1) n_d++;
            tests++;
            if (c_ack !== !exp_d || d_ack !== exp_d) begin
                fails++;
                $display("FAIL b2b_ack[%0d]: c_ack=%b d_ack=%b required %b %b", i, c_ack, d_ack, !exp_d, exp_d);
            end
            if (i == 11) begin
                c_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
            end
            tick();
        end
        tests++;
        if (n_c != 6 || n_d != 6) begin
            fails++;
            $display("FAIL b2b_counts: c_acks=%0d d_acks=%0d required 6 6", n_c, n_d);
        end
    endtask

    task automatic test_dma_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; m_ack = 1'b0;
        m_rdata = 32'h1357_9BDF;
        tick();
        tests++;
        if (grant !== 2'b10 || m_we !== 1'b1 || m_addr !== 32'h40 || m_wdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL write_latch: grant=%b m_we=%b m_addr=%h m_wdata=%h required 10 1 00000040 deadbeef",
                     grant, m_we, m_addr, m_wdata);
        end
        d_addr = 32'h99; d_wdata = 32'h0; d_we = 1'b0;
        tick();
        tests++;
        if (m_addr !== 32'h40 || m_wdata !== 32'hDEAD_BEEF || m_we !== 1'b1 || m_req !== 1'b1) begin
            fails++;
            $display("FAIL write_hold: m_addr=%h m_wdata=%h m_we=%b m_req=%b required 00000040 deadbeef 1 1",
                     m_addr, m_wdata, m_we, m_req);
        end
        m_ack = 1'b1;
        tick();
        tests++;
        if (d_ack !== 1'b1 || d_rdata !== '0 || err !== 1'b0 || m_addr !== 32'h40) begin
            fails++;
            $display("FAIL write_done: d_ack=%b d_rdata=%h err=%b m_addr=%h required 1 00000000 0 00000040",
                     d_ack, d_rdata, err, m_addr);
        end
        d_req = 1'b0; m_ack = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20; m_ack = 1'b0; m_rdata = 32'hFFFF_FFFF;
        tick();
        for (int i = 2; i <= 15; i++) begin
            tick();
            tests++;
            if (m_req !== 1'b1 || c_ack !== 1'b0 || err !== 1'b0) begin
                fails++;
                $display("FAIL timeout_wait[%0d]: m_req=%b c_ack=%b err=%b required 1 0 0", i, m_req, c_ack, err);
            end
        end
        tick();
        tests++;
        if (c_ack !== 1'b1 || err !== 1'b1 || c_rdata !== '0 || m_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout_abort: c_ack=%b err=%b c_rdata=%h m_req=%b required 1 1 00000000 0",
                     c_ack, err, c_rdata, m_req);
        end
        c_req = 1'b0;
        tick();
        tests++;
        if (err !== 1'b0 || busy !== 1'b0 || c_ack !== 1'b0) begin
            fails++;
            $display("FAIL timeout_idle: err=%b busy=%b c_ack=%b required 0 0 0", err, busy, c_ack);
        end
        c_req = 1'b1; c_addr = 32'h24;
        tick();
        m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
        tick();
        tests++;
        if (c_ack !== 1'b1 || err !== 1'b0 || c_rdata !== 32'h0BAD_F00D) begin
            fails++;
            $display("FAIL timeout_recover: c_ack=%b err=%b c_rdata=%h required 1 0 0badf00d", c_ack, err, c_rdata);
        end
        c_req = 1'b0; m_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30; m_ack = 1'b0;
        tick(); tick(); tick();
        tests++;
        if (m_req !== 1'b1 || grant !== 2'b01) begin
            fails++;
            $display("FAIL abort_pre: m_req=%b grant=%b required 1 01", m_req, grant);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (m_req !== 1'b0 || grant !== 2'b00 || c_ack !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: m_req=%b grant=%b c_ack=%b busy=%b required 0 00 0 0", m_req, grant, c_ack, busy);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (m_req !== 1'b1 || grant !== 2'b01 || c_ack !== 1'b0) begin
            fails++;
            $display("FAIL abort_regrant: m_req=%b grant=%b c_ack=%b required 1 01 0", m_req, grant, c_ack);
        end
        m_ack = 1'b1; m_rdata = 32'h0000_0C0C;
        tick();
        tests++;
        if (c_ack !== 1'b1 || c_rdata !== 32'h0000_0C0C) begin
            fails++;
            $display("FAIL abort_complete: c_ack=%b c_rdata=%h required 1 00000c0c", c_ack, c_rdata);
        end
        c_req = 1'b0; m_ack = 1'b0;
        tick();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_cpu_read();
        test_back_to_back();
        test_dma_write();
        test_timeout();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
